// File: rtl/fetch2_ras_pkg.sv
// rtl/fetch2_ras_pkg.sv - shared constants, branch-type encodings and checkpoint packet for the Fetch-2 RAS
// Optional feature macro: RAS_VALID_COUNT_EN (adds occupancy count to the checkpoint)
package fetch2_ras_pkg;

  localparam int SIZE_PC           = 32;
  localparam int BRANCH_TYPE_LOG   = 2;
  localparam int DEFAULT_RAS_DEPTH = 16;
  localparam int DEFAULT_RAS_PTR_W = 4;

  // Branch-type encodings shared with pre-decode
  localparam logic [BRANCH_TYPE_LOG-1:0] COND_BRANCH = 2'd0;
  localparam logic [BRANCH_TYPE_LOG-1:0] JUMP_TYPE   = 2'd1;
  localparam logic [BRANCH_TYPE_LOG-1:0] CALL        = 2'd2;
  localparam logic [BRANCH_TYPE_LOG-1:0] RETURN      = 2'd3;

  // Checkpoint carried down the pipe with each control instruction
  typedef struct packed {
    logic [DEFAULT_RAS_PTR_W-1:0] ptr;
    logic [SIZE_PC-1:0]           top;
`ifdef RAS_VALID_COUNT_EN
    logic [DEFAULT_RAS_PTR_W:0]   cnt;
`endif
  } rasCkptPkt;

  // Return address of a call: the next sequential instruction, wrapping at 2^SIZE_PC
  function automatic logic [SIZE_PC-1:0] ret_addr(input logic [SIZE_PC-1:0] pc);
    return pc + SIZE_PC'(4);
  endfunction

endpackage

// File: rtl/ras_regfile.sv
// rtl/ras_regfile.sv - RAS entry storage: 1 async read port, 2 sync write ports (A wins over B)
module ras_regfile #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata,
  input  logic             we_a,
  input  logic [PTR_W-1:0] waddr_a,
  input  logic [WIDTH-1:0] wdata_a,
  input  logic             we_b,
  input  logic [PTR_W-1:0] waddr_b,
  input  logic [WIDTH-1:0] wdata_b
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Next array contents: port B first so port A overrides on an index collision
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we_b) begin
      mem_d[waddr_b] = wdata_b;
    end
    if (we_a) begin
      mem_d[waddr_a] = wdata_a;
    end
  end

  // Entry storage; every entry clears to zero on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch2_ras.sv
// rtl/fetch2_ras.sv - Fetch-2 return address stack with checkpoint/recovery; optional macro RAS_VALID_COUNT_EN
module fetch2_ras
  import fetch2_ras_pkg::*;
#(
  parameter int RAS_DEPTH = 16,
  parameter int RAS_PTR_W = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall_i,
  input  logic                       ctrlValid_i,
  input  logic [BRANCH_TYPE_LOG-1:0] ctrlType_i,
  input  logic [SIZE_PC-1:0]         pc_i,
  output logic [SIZE_PC-1:0]         rasTarget_o,
  output logic                       rasValid_o,
  output logic [RAS_PTR_W-1:0]       rasPtr_o,
  output logic [SIZE_PC-1:0]         rasTop_o,
`ifdef RAS_VALID_COUNT_EN
  output logic [RAS_PTR_W:0]         rasCnt_o,
  input  logic [RAS_PTR_W:0]         recoverCnt_i,
`endif
  input  logic                       recover_i,
  input  logic [RAS_PTR_W-1:0]       recoverPtr_i,
  input  logic [SIZE_PC-1:0]         recoverTop_i,
  input  logic [BRANCH_TYPE_LOG-1:0] recoverType_i,
  input  logic [SIZE_PC-1:0]         recoverPC_i
);

  localparam logic [RAS_PTR_W-1:0] PTR_ONE = 1;

  logic [RAS_PTR_W-1:0]       ptr_q, ptr_d;
  logic [RAS_PTR_W-1:0]       base_ptr;
  logic                       op_valid;
  logic [BRANCH_TYPE_LOG-1:0] op_type;
  logic [SIZE_PC-1:0]         op_pc;
  logic                       we_a, we_b;
  logic [RAS_PTR_W-1:0]       waddr_a, waddr_b;
  logic [SIZE_PC-1:0]         wdata_a, wdata_b;
  logic [SIZE_PC-1:0]         tos_data;

`ifdef RAS_VALID_COUNT_EN
  localparam logic [RAS_PTR_W:0] CNT_ONE = 1;
  localparam logic [RAS_PTR_W:0] CNT_MAX = (RAS_PTR_W+1)'(RAS_DEPTH);
  logic [RAS_PTR_W:0] cnt_q, cnt_d;
  logic [RAS_PTR_W:0] base_cnt;
`endif

  // Pick the operation source (recovery replay or live pre-decode) and compute the next pointer and writes
  always_comb begin
    we_b     = 1'b0;
    waddr_b  = recoverPtr_i;
    wdata_b  = recoverTop_i;
    op_valid = ctrlValid_i & ~stall_i;
    op_type  = ctrlType_i;
    op_pc    = pc_i;
    base_ptr = ptr_q;
`ifdef RAS_VALID_COUNT_EN
    base_cnt = cnt_q;
`endif
    if (recover_i) begin
      // Restore the checkpoint first, then replay the redirecting instruction on top of it
      we_b     = 1'b1;
      op_valid = 1'b1;
      op_type  = recoverType_i;
      op_pc    = recoverPC_i;
      base_ptr = recoverPtr_i;
`ifdef RAS_VALID_COUNT_EN
      base_cnt = recoverCnt_i;
`endif
    end

    ptr_d   = base_ptr;
    we_a    = 1'b0;
    waddr_a = base_ptr + PTR_ONE;
    wdata_a = ret_addr(op_pc);
`ifdef RAS_VALID_COUNT_EN
    cnt_d   = base_cnt;
`endif
    if (op_valid) begin
      case (op_type)
        CALL: begin
          ptr_d = base_ptr + PTR_ONE;
          we_a  = 1'b1;
`ifdef RAS_VALID_COUNT_EN
          cnt_d = (base_cnt == CNT_MAX) ? base_cnt : base_cnt + CNT_ONE;
`endif
        end
        RETURN: begin
`ifdef RAS_VALID_COUNT_EN
          // Popping an empty stack is a no-op so the pointer never drifts below the oldest entry
          if (base_cnt != '0) begin
            ptr_d = base_ptr - PTR_ONE;
            cnt_d = base_cnt - CNT_ONE;
          end
`else
          ptr_d = base_ptr - PTR_ONE;
`endif
        end
        default: begin
          ptr_d = base_ptr;
        end
      endcase
    end
  end

  // Stack pointer (and occupancy) register; reset overrides recovery
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
`ifdef RAS_VALID_COUNT_EN
      cnt_q <= '0;
`endif
    end else begin
      ptr_q <= ptr_d;
`ifdef RAS_VALID_COUNT_EN
      cnt_q <= cnt_d;
`endif
    end
  end

  ras_regfile #(
    .DEPTH (RAS_DEPTH),
    .PTR_W (RAS_PTR_W),
    .WIDTH (SIZE_PC)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .raddr   (ptr_q),
    .rdata   (tos_data),
    .we_a    (we_a),
    .waddr_a (waddr_a),
    .wdata_a (wdata_a),
    .we_b    (we_b),
    .waddr_b (waddr_b),
    .wdata_b (wdata_b)
  );

  // Prediction and checkpoint outputs are pre-edge views of the registered state
  always_comb begin
    rasTarget_o = tos_data;
    rasTop_o    = tos_data;
    rasPtr_o    = ptr_q;
`ifdef RAS_VALID_COUNT_EN
    rasCnt_o    = cnt_q;
    rasValid_o  = (cnt_q != '0);
`else
    rasValid_o  = ~reset;
`endif
  end

endmodule

// File: tb/tb_fetch2_ras.sv
// tb/tb_fetch2_ras.sv - directed self-checking bench for fetch2_ras
module tb_fetch2_ras;
  import fetch2_ras_pkg::*;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       stall_i;
  logic                       ctrlValid_i;
  logic [BRANCH_TYPE_LOG-1:0] ctrlType_i;
  logic [SIZE_PC-1:0]         pc_i;
  logic [SIZE_PC-1:0]         rasTarget_o;
  logic                       rasValid_o;
  logic [3:0]                 rasPtr_o;
  logic [SIZE_PC-1:0]         rasTop_o;
  logic                       recover_i;
  logic [3:0]                 recoverPtr_i;
  logic [SIZE_PC-1:0]         recoverTop_i;
  logic [BRANCH_TYPE_LOG-1:0] recoverType_i;
  logic [SIZE_PC-1:0]         recoverPC_i;
`ifdef RAS_VALID_COUNT_EN
  logic [4:0]                 rasCnt_o;
  logic [4:0]                 recoverCnt_i;
`endif

  int n_cmp = 0;
  int n_err = 0;

  fetch2_ras #(.RAS_DEPTH(16), .RAS_PTR_W(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall_i),
    .ctrlValid_i   (ctrlValid_i),
    .ctrlType_i    (ctrlType_i),
    .pc_i          (pc_i),
    .rasTarget_o   (rasTarget_o),
    .rasValid_o    (rasValid_o),
    .rasPtr_o      (rasPtr_o),
    .rasTop_o      (rasTop_o),
`ifdef RAS_VALID_COUNT_EN
    .rasCnt_o      (rasCnt_o),
    .recoverCnt_i  (recoverCnt_i),
`endif
    .recover_i     (recover_i),
    .recoverPtr_i  (recoverPtr_i),
    .recoverTop_i  (recoverTop_i),
    .recoverType_i (recoverType_i),
    .recoverPC_i   (recoverPC_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall_i       = 1'b0;
    ctrlValid_i   = 1'b0;
    ctrlType_i    = COND_BRANCH;
    pc_i          = '0;
    recover_i     = 1'b0;
    recoverPtr_i  = '0;
    recoverTop_i  = '0;
    recoverType_i = COND_BRANCH;
    recoverPC_i   = '0;
`ifdef RAS_VALID_COUNT_EN
    recoverCnt_i  = '0;
`endif
  endtask

  task automatic op(input logic [BRANCH_TYPE_LOG-1:0] t, input logic [SIZE_PC-1:0] pc);
    ctrlValid_i = 1'b1;
    ctrlType_i  = t;
    pc_i        = pc;
    tick();
    idle();
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++; if (rasValid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid_during got=%0h exp=0", rasValid_o); end
    reset = 1'b0;
    #1;
    n_cmp++; if (rasTarget_o !== 32'h0) begin n_err++; $display("FAIL reset_target got=%0h exp=0", rasTarget_o); end
    n_cmp++; if (rasPtr_o !== 4'd0) begin n_err++; $display("FAIL reset_ptr got=%0h exp=0", rasPtr_o); end
    n_cmp++; if (rasTop_o !== 32'h0) begin n_err++; $display("FAIL reset_top got=%0h exp=0", rasTop_o); end
`ifdef RAS_VALID_COUNT_EN
    n_cmp++; if (rasValid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%0h exp=0", rasValid_o); end
    n_cmp++; if (rasCnt_o !== 5'd0) begin n_err++; $display("FAIL reset_cnt got=%0h exp=0", rasCnt_o); end
`else
    n_cmp++; if (rasValid_o !== 1'b1) begin n_err++; $display("FAIL reset_valid got=%0h exp=1", rasValid_o); end
`endif
  endtask

  task automatic test_call_return();
    do_reset();
    op(CALL, 32'h1000);
    n_cmp++; if (rasTarget_o !== 32'h1004) begin n_err++; $display("FAIL call_target got=%0h exp=1004", rasTarget_o); end
    n_cmp++; if (rasPtr_o !== 4'd1) begin n_err++; $display("FAIL call_ptr got=%0h exp=1", rasPtr_o); end
    n_cmp++; if (rasValid_o !== 1'b1) begin n_err++; $display("FAIL call_valid got=%0h exp=1", rasValid_o); end
    op(RETURN, 32'h1100);
    n_cmp++; if (rasPtr_o !== 4'd0) begin n_err++; $display("FAIL ret_ptr got=%0h exp=0", rasPtr_o); end
    op(JUMP_TYPE, 32'h1200);
    n_cmp++; if (rasPtr_o !== 4'd0) begin n_err++; $display("FAIL jump_ptr got=%0h exp=0", rasPtr_o); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      op(CALL, 32'h100 * i);
    end
    n_cmp++; if (rasTarget_o !== 32'h1104) begin n_err++; $display("FAIL ovf_tos got=%0h exp=1104", rasTarget_o); end
    n_cmp++; if (rasPtr_o !== 4'd1) begin n_err++; $display("FAIL ovf_ptr got=%0h exp=1", rasPtr_o); end
`ifdef RAS_VALID_COUNT_EN
    n_cmp++; if (rasCnt_o !== 5'd16) begin n_err++; $display("FAIL ovf_cnt got=%0h exp=16", rasCnt_o); end
`endif
    for (int k = 1; k <= 16; k++) begin
      if (k == 2) begin
        n_cmp++; if (rasTarget_o !== 32'h1004) begin n_err++; $display("FAIL ovf_pop2 got=%0h exp=1004", rasTarget_o); end
      end
      if (k == 16) begin
        n_cmp++; if (rasTarget_o !== 32'h204) begin n_err++; $display("FAIL ovf_pop16 got=%0h exp=204", rasTarget_o); end
      end
      op(RETURN, 32'h0);
    end
    n_cmp++; if (rasPtr_o !== 4'd1) begin n_err++; $display("FAIL ovf_ptr_end got=%0h exp=1", rasPtr_o); end
`ifdef RAS_VALID_COUNT_EN
    n_cmp++; if (rasValid_o !== 1'b0) begin n_err++; $display("FAIL ovf_valid_end got=%0h exp=0", rasValid_o); end
`endif
  endtask

  task automatic test_underflow();
    do_reset();
    op(RETURN, 32'h500);
`ifdef RAS_VALID_COUNT_EN
    n_cmp++; if (rasPtr_o !== 4'd0) begin n_err++; $display("FAIL udf_ptr got=%0h exp=0", rasPtr_o); end
    n_cmp++; if (rasValid_o !== 1'b0) begin n_err++; $display("FAIL udf_valid got=%0h exp=0", rasValid_o); end
`else
    n_cmp++; if (rasPtr_o !== 4'd15) begin n_err++; $display("FAIL udf_ptr got=%0h exp=f", rasPtr_o); end
    n_cmp++; if (rasTarget_o !== 32'h0) begin n_err++; $display("FAIL udf_target got=%0h exp=0", rasTarget_o); end
`endif
  endtask

  task automatic test_recover_cond();
    rasCkptPkt ck;
    do_reset();
    op(CALL, 32'h10);
    op(CALL, 32'h20);
    op(CALL, 32'h30);
    op(RETURN, 32'h40);
    op(CALL, 32'h2000);
    n_cmp++; if (rasTarget_o !== 32'h2004) begin n_err++; $display("FAIL spec_tos got=%0h exp=2004", rasTarget_o); end
    ck.ptr = 4'd3;
    ck.top = 32'hABC;
`ifdef RAS_VALID_COUNT_EN
    ck.cnt = 5'd3;
    recoverCnt_i = ck.cnt;
`endif
    recover_i     = 1'b1;
    recoverPtr_i  = ck.ptr;
    recoverTop_i  = ck.top;
    recoverType_i = COND_BRANCH;
    recoverPC_i   = 32'h600;
    tick();
    idle();
    n_cmp++; if (rasPtr_o !== 4'd3) begin n_err++; $display("FAIL rcv_cond_ptr got=%0h exp=3", rasPtr_o); end
    n_cmp++; if (rasTarget_o !== 32'hABC) begin n_err++; $display("FAIL rcv_cond_tos got=%0h exp=abc", rasTarget_o); end
`ifdef RAS_VALID_COUNT_EN
    n_cmp++; if (rasCnt_o !== 5'd3) begin n_err++; $display("FAIL rcv_cond_cnt got=%0h exp=3", rasCnt_o); end
`endif
    op(RETURN, 32'h0);
    n_cmp++; if (rasTarget_o !== 32'h24) begin n_err++; $display("FAIL rcv_cond_below got=%0h exp=24", rasTarget_o); end
  endtask

  task automatic test_recover_call();
    recover_i     = 1'b1;
    recoverPtr_i  = 4'd5;
    recoverTop_i  = 32'h555;
    recoverType_i = CALL;
    recoverPC_i   = 32'h3000;
`ifdef RAS_VALID_COUNT_EN
    recoverCnt_i  = 5'd5;
`endif
    ctrlValid_i   = 1'b1;
    ctrlType_i    = CALL;
    pc_i          = 32'h7000;
    tick();
    idle();
    n_cmp++; if (rasPtr_o !== 4'd6) begin n_err++; $display("FAIL rcv_call_ptr got=%0h exp=6", rasPtr_o); end
    n_cmp++; if (rasTarget_o !== 32'h3004) begin n_err++; $display("FAIL rcv_call_tos got=%0h exp=3004", rasTarget_o); end
`ifdef RAS_VALID_COUNT_EN
    n_cmp++; if (rasCnt_o !== 5'd6) begin n_err++; $display("FAIL rcv_call_cnt got=%0h exp=6", rasCnt_o); end
`endif
    op(RETURN, 32'h0);
    n_cmp++; if (rasTarget_o !== 32'h555) begin n_err++; $display("FAIL rcv_call_restored got=%0h exp=555", rasTarget_o); end
    op(RETURN, 32'h0);
    n_cmp++; if (rasTarget_o !== 32'h0) begin n_err++; $display("FAIL rcv_call_e4 got=%0h exp=0", rasTarget_o); end
    op(RETURN, 32'h0);
    n_cmp++; if (rasTarget_o !== 32'hABC) begin n_err++; $display("FAIL rcv_call_e3 got=%0h exp=abc", rasTarget_o); end
  endtask

  task automatic test_stall();
    stall_i     = 1'b1;
    ctrlValid_i = 1'b1;
    ctrlType_i  = CALL;
    pc_i        = 32'h9000;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if (rasPtr_o !== 4'd3) begin n_err++; $display("FAIL stall_ptr cyc=%0d got=%0h exp=3", c, rasPtr_o); end
      n_cmp++; if (rasTarget_o !== 32'hABC) begin n_err++; $display("FAIL stall_tos cyc=%0d got=%0h exp=abc", c, rasTarget_o); end
    end
    idle();
  endtask

  task automatic test_back_to_back();
    ctrlValid_i = 1'b1;
    ctrlType_i  = CALL;
    pc_i        = 32'h4000;
    tick();
    ctrlType_i  = RETURN;
    pc_i        = 32'h4100;
    n_cmp++; if (rasTarget_o !== 32'h4004) begin n_err++; $display("FAIL b2b_pred got=%0h exp=4004", rasTarget_o); end
    tick();
    idle();
    n_cmp++; if (rasPtr_o !== 4'd3) begin n_err++; $display("FAIL b2b_ptr got=%0h exp=3", rasPtr_o); end
    n_cmp++; if (rasTop_o !== 32'hABC) begin n_err++; $display("FAIL b2b_top got=%0h exp=abc", rasTop_o); end
  endtask

  task automatic test_reset_wins();
    recover_i     = 1'b1;
    recoverPtr_i  = 4'd7;
    recoverTop_i  = 32'h777;
    recoverType_i = CALL;
    recoverPC_i   = 32'h8000;
    reset         = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    #1;
    n_cmp++; if (rasPtr_o !== 4'd0) begin n_err++; $display("FAIL rst_win_ptr got=%0h exp=0", rasPtr_o); end
    n_cmp++; if (rasTarget_o !== 32'h0) begin n_err++; $display("FAIL rst_win_tos got=%0h exp=0", rasTarget_o); end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_call_return();
    test_overflow();
    test_underflow();
    test_recover_cond();
    test_recover_call();
    test_stall();
    test_back_to_back();
    test_reset_wins();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch2_ras.md
# fetch2_ras

Return address stack for the Fetch-2 stage. It consumes the control-type classification produced by pre-decode for the selected control instruction of the fetch bundle. It supplies the predicted target for `RETURN` instructions and pushes the return address for `CALL` instructions. On a backend redirect it restores its state from a checkpoint carried with the instruction.

## Interface
Parameters:
- `RAS_DEPTH`, default 16: number of entries; must be a power of two.
- `RAS_PTR_W`, default 4: log2(`RAS_DEPTH`).

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `stall_i` in 1: Fetch-2 stalled; suppresses normal updates.
- `ctrlValid_i` in 1: a pre-decoded control instruction is present this cycle.
- `ctrlType_i` in `BRANCH_TYPE_LOG`: `CALL`, `RETURN`, `JUMP_TYPE` or `COND_BRANCH`.
- `pc_i` in `SIZE_PC`: PC of that instruction.
- `rasTarget_o` out `SIZE_PC`: entry at the top of stack (TOS).
- `rasValid_o` out 1: `rasTarget_o` is meaningful.
- `rasPtr_o` out `RAS_PTR_W`: checkpoint pointer, taken before this cycle's operation.
- `rasTop_o` out `SIZE_PC`: checkpoint TOS value, taken before this cycle's operation.
- `rasCnt_o` out `RAS_PTR_W+1`: checkpoint occupancy. Present only with `RAS_VALID_COUNT_EN`.
- `recover_i` in 1: backend redirect; restore from the checkpoint inputs.
- `recoverPtr_i` in `RAS_PTR_W`; `recoverTop_i` in `SIZE_PC`; `recoverCnt_i` in `RAS_PTR_W+1` (present only with the macro): returned checkpoint.
- `recoverType_i` in `BRANCH_TYPE_LOG`; `recoverPC_i` in `SIZE_PC`: type and PC of the redirecting instruction, whose own effect is re-applied.

## Operation
State:
- `ptr` points at the last pushed entry (TOS).
- `stack[RAS_DEPTH]` holds the entries.
- `cnt` tracks occupancy (macro only).

Priority, highest first: `reset` > `recover_i` > `stall_i` > normal update.

Normal update, when `ctrlValid_i` and not `stall_i`:
- `CALL`: `ptr <= ptr+1`, `stack[ptr+1] <= pc_i+4`.
- `RETURN`: `ptr <= ptr-1`.
- `JUMP_TYPE` and `COND_BRANCH`: no change.

Recovery:
- First restore the checkpoint: `ptr = recoverPtr_i`, `stack[recoverPtr_i] <= recoverTop_i`.
- Then apply `recoverType_i` exactly as a normal update, using `recoverPC_i`. A `CALL` therefore also writes `stack[recoverPtr_i+1] <= recoverPC_i+4`.
- Inputs `ctrlValid_i`, `ctrlType_i` and `pc_i` are ignored that cycle.

Arithmetic and widths:
- Pointer arithmetic is modulo `RAS_DEPTH`. Overflow overwrites the oldest entry silently.
- Return address is `pc_i+4` modulo 2^`SIZE_PC`.

Outputs:
- Checkpoint outputs always reflect the state before the edge.
- `rasTarget_o = stack[ptr]`.
- A downstream mux selects `rasTarget_o` over the pre-decode `takenPC` when the type is `RETURN`.

## Timing
- `rasTarget_o`, `rasValid_o` and the checkpoint outputs are combinational reads of registered state, valid in the same cycle as `ctrlType_i`.
- Updates take effect at the next rising `clk`. A push is visible one cycle later; back-to-back `CALL` then `RETURN` returns the pushed value.
- Recovery takes one cycle. Predictions in the recovery cycle are discarded by fetch.
- Reset values: `ptr=0`, all entries 0, `cnt=0`; `rasTarget_o=0`, `rasPtr_o=0`, `rasTop_o=0`, `rasCnt_o=0`, `rasValid_o` as defined under Configuration.
- `stall_i` held: state frozen and outputs stable.
- `reset` asserted mid-recovery wins.

## Configuration
`RAS_VALID_COUNT_EN`:
- Defined:
  - `cnt` saturates at `RAS_DEPTH` on push and at 0 on pop.
  - `rasValid_o = (cnt != 0)`.
  - `cnt` is checkpointed and restored, with the re-applied operation on top.
  - `RETURN` on empty leaves `ptr` and `cnt` unchanged.
- Undefined:
  - No `cnt`; `rasCnt_o` and `recoverCnt_i` are absent.
  - `rasValid_o` is tied 1 (0 only while `reset` is high).
  - Underflow wraps and returns stale entries.

## Structure
- Shared package/defines: `RAS_DEPTH`, `RAS_PTR_W`, and a checkpoint struct `rasCkptPkt` {ptr, top, cnt under the macro}. Branch-type encodings are reused.
- One sub-module, `ras_regfile`: 1 read, 2 write ports, synchronous write and asynchronous read. Write port B serves the recovery-restore entry; port A serves push entries. Port A wins if both target the same index.

## Test plan
- Reset, then `CALL` at pc 0x1000 → next cycle `rasTarget_o=0x1004`, `rasPtr_o=1`; then `RETURN` → following cycle `rasPtr_o=0`.
- 17 `CALL`s with `RAS_DEPTH`=16 at pcs 0x100, 0x200, … → TOS holds 0x1104; the 16th pop returns 0x204 (the first entry was overwritten); `cnt` saturates at 16.
- With the macro, `RETURN` on an empty stack → `rasValid_o=0`, `ptr` unchanged. Without the macro → `ptr` wraps to 15.
- Speculative `RETURN` then `CALL` at pc 0x2000 corrupts the TOS; `recover_i` with the checkpoint {ptr=3, top=0xABC} and `COND_BRANCH` → `stack[3]=0xABC`, `ptr=3`.
- `recover_i` with `recoverType_i=CALL`, `recoverPC_i=0x3000`, `ptr=5` → `ptr=6`, `stack[6]=0x3004`; simultaneous `ctrlValid_i` `CALL` is ignored.
- `stall_i` held for 3 cycles with `CALL` presented → no state change; `rasTarget_o` stable.
